// File: rtl/run_detector_onehot.sv
// One-hot Moore detector for runs of RUN_LEN equal bits on a serial input,
// with overlap mode, sample enable, saturating hit counter and illegal-state recovery.
module run_detector_onehot #(
    parameter int unsigned RUN_LEN = 2,
    parameter int unsigned OVERLAP = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rs,
    input  logic                 en,
    input  logic                 w,
    output logic                 z,
    output logic                 z_val,
    output logic [2*RUN_LEN:0]   state,
    output logic [CNT_W-1:0]     det_count,
    output logic                 illegal
);

    localparam int unsigned SW   = 2 * RUN_LEN + 1;
    localparam int unsigned ZN   = RUN_LEN;
    localparam int unsigned O1   = RUN_LEN + 1;
    localparam int unsigned ON   = 2 * RUN_LEN;
    localparam bit          OVL  = (OVERLAP != 0);

    localparam logic [SW-1:0]    ST_A    = SW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SW-1:0]    state_q;
    logic [SW-1:0]    state_d;
    logic [SW-1:0]    run_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             in_zeros;
    logic             in_ones;
    logic             hit;

    // Moore outputs decode the state register directly; no path from w or en.
    assign state     = state_q;
    assign det_count = cnt_q;
    assign z         = state_q[ZN] | state_q[ON];
    assign z_val     = state_q[ON];
    assign illegal   = (state_q == '0) || ((state_q & (state_q - SW'(1))) != '0);

    // Per-bit one-hot successor for a legal state consuming w.
    always_comb begin : run_next
        run_d    = '0;
        in_zeros = |state_q[ZN:1];
        in_ones  = |state_q[ON:O1];

        run_d[1]  = ~w & (state_q[0] | in_ones  | (!OVL & state_q[ZN]));
        run_d[O1] =  w & (state_q[0] | in_zeros | (!OVL & state_q[ON]));
        for (int unsigned k = 2; k <= RUN_LEN; k++) begin
            run_d[k]           = ~w & state_q[k-1];
            run_d[RUN_LEN + k] =  w & state_q[RUN_LEN + k - 1];
        end
        // Terminal states hold while the run continues in overlap mode.
        run_d[ZN] = run_d[ZN] | (~w & OVL & state_q[ZN]);
        run_d[ON] = run_d[ON] | ( w & OVL & state_q[ON]);
    end

    // Next state and counter; illegal recovery overrides en and holds the count.
    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        hit     = run_d[ZN] | run_d[ON];
        if (illegal) begin
            state_d = ST_A;
        end else if (en) begin
            state_d = run_d;
            if (hit && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (!rs) begin
            state_q <= ST_A;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_run_detector_onehot.sv
// Scoreboard bench for run_detector_onehot: three parameterisations driven by
// directed vectors; a monitor compares each post-edge sample against the queue.
module tb_run_detector_onehot;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rs_a = 1'b1, en_a = 1'b0, w_a = 1'b0;
    logic rs_b = 1'b1, en_b = 1'b0, w_b = 1'b0;
    logic rs_c = 1'b1, en_c = 1'b0, w_c = 1'b0;

    logic       z_a, zv_a, ill_a;
    logic [4:0] st_a;
    logic [7:0] cnt_a;
    logic       z_b, zv_b, ill_b;
    logic [6:0] st_b;
    logic [7:0] cnt_b;
    logic       z_c, zv_c, ill_c;
    logic [4:0] st_c;
    logic [1:0] cnt_c;

    run_detector_onehot #(.RUN_LEN(2), .OVERLAP(1), .CNT_W(8)) u_a (
        .clk(clk), .rs(rs_a), .en(en_a), .w(w_a), .z(z_a), .z_val(zv_a),
        .state(st_a), .det_count(cnt_a), .illegal(ill_a));
    run_detector_onehot #(.RUN_LEN(3), .OVERLAP(0), .CNT_W(8)) u_b (
        .clk(clk), .rs(rs_b), .en(en_b), .w(w_b), .z(z_b), .z_val(zv_b),
        .state(st_b), .det_count(cnt_b), .illegal(ill_b));
    run_detector_onehot #(.RUN_LEN(2), .OVERLAP(1), .CNT_W(2)) u_c (
        .clk(clk), .rs(rs_c), .en(en_c), .w(w_c), .z(z_c), .z_val(zv_c),
        .state(st_c), .det_count(cnt_c), .illegal(ill_c));

    typedef struct {
        int         id;
        logic [6:0] st;
        logic       z;
        logic       zv;
        logic [7:0] cnt;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input string field,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, field, act, exp);
        end
    endtask

    // Drive one edge on the selected DUT (others hold with en=0) and queue its expectation.
    task automatic step(input int id, input logic r, input logic e, input logic wv,
                        input logic [6:0] st, input logic ez, input logic ezv,
                        input logic [7:0] c, input string tag);
        exp_t x;
        @(negedge clk);
        rs_a = 1'b1; en_a = 1'b0;
        rs_b = 1'b1; en_b = 1'b0;
        rs_c = 1'b1; en_c = 1'b0;
        case (id)
            0:       begin rs_a = r; en_a = e; w_a = wv; end
            1:       begin rs_b = r; en_b = e; w_b = wv; end
            default: begin rs_c = r; en_c = e; w_c = wv; end
        endcase
        x.id = id; x.st = st; x.z = ez; x.zv = ezv; x.cnt = c; x.tag = tag;
        sb.push_back(x);
    endtask

    // Monitor: one expectation per edge, sampled just after the rising edge.
    initial begin : monitor
        exp_t       e;
        logic [6:0] ast;
        logic       az, azv, ail;
        logic [7:0] acnt;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.id)
                    0:       begin ast = 7'(st_a); az = z_a; azv = zv_a; ail = ill_a; acnt = cnt_a; end
                    1:       begin ast = st_b;     az = z_b; azv = zv_b; ail = ill_b; acnt = cnt_b; end
                    default: begin ast = 7'(st_c); az = z_c; azv = zv_c; ail = ill_c; acnt = 8'(cnt_c); end
                endcase
                chk(e.tag, "state",     8'(ast),  8'(e.st));
                chk(e.tag, "z",         8'(az),   8'(e.z));
                if (e.z) chk(e.tag, "z_val", 8'(azv), 8'(e.zv));
                chk(e.tag, "det_count", acnt,     e.cnt);
                chk(e.tag, "illegal",   8'(ail),  8'd0);
            end
        end
    end

    initial begin : stimulus
        // DUT a: RUN_LEN=2, overlap. A=00001 Z1=00010 Z2=00100 O1=01000 O2=10000
        step(0, 1'b0, 1'b1, 1'b0, 7'b0000001, 1'b0, 1'b0, 8'd0, "a_reset");
        step(0, 1'b1, 1'b1, 1'b0, 7'b0000010, 1'b0, 1'b0, 8'd0, "a_z1");
        step(0, 1'b1, 1'b1, 1'b0, 7'b0000100, 1'b1, 1'b0, 8'd1, "a_z2");
        step(0, 1'b1, 1'b1, 1'b0, 7'b0000100, 1'b1, 1'b0, 8'd2, "a_z2_overlap");
        step(0, 1'b1, 1'b1, 1'b1, 7'b0001000, 1'b0, 1'b0, 8'd2, "a_o1");
        step(0, 1'b1, 1'b1, 1'b0, 7'b0000010, 1'b0, 1'b0, 8'd2, "a_back_z1");
        step(0, 1'b1, 1'b0, 1'b1, 7'b0000010, 1'b0, 1'b0, 8'd2, "a_en0_1");
        step(0, 1'b1, 1'b0, 1'b0, 7'b0000010, 1'b0, 1'b0, 8'd2, "a_en0_2");
        step(0, 1'b1, 1'b0, 1'b1, 7'b0000010, 1'b0, 1'b0, 8'd2, "a_en0_3");
        step(0, 1'b1, 1'b1, 1'b0, 7'b0000100, 1'b1, 1'b0, 8'd3, "a_en1_z2");
        step(0, 1'b1, 1'b1, 1'b1, 7'b0001000, 1'b0, 1'b0, 8'd3, "a_alt_o1");
        step(0, 1'b1, 1'b1, 1'b0, 7'b0000010, 1'b0, 1'b0, 8'd3, "a_alt_z1");
        step(0, 1'b1, 1'b1, 1'b1, 7'b0001000, 1'b0, 1'b0, 8'd3, "a_alt_o1b");
        step(0, 1'b1, 1'b1, 1'b1, 7'b0010000, 1'b1, 1'b1, 8'd4, "a_o2");

        // Corrupt the state, check the flag, then recover on an en=0 edge.
        @(posedge clk);
        #2;
        force u_a.state_q = 5'b00110;
        #1;
        chk("a_forced", "illegal", 8'(ill_a), 8'd1);
        release u_a.state_q;
        step(0, 1'b1, 1'b0, 1'b1, 7'b0000001, 1'b0, 1'b0, 8'd4, "a_recover");
        step(0, 1'b1, 1'b1, 1'b1, 7'b0001000, 1'b0, 1'b0, 8'd4, "a_from_a_o1");
        step(0, 1'b1, 1'b1, 1'b1, 7'b0010000, 1'b1, 1'b1, 8'd5, "a_o2_again");
        step(0, 1'b0, 1'b1, 1'b1, 7'b0000001, 1'b0, 1'b0, 8'd0, "a_midrun_reset");

        // DUT b: RUN_LEN=3, non-overlap. O1..O3 = bits 4..6, Z1..Z3 = bits 1..3
        step(1, 1'b0, 1'b0, 1'b0, 7'b0000001, 1'b0, 1'b0, 8'd0, "b_reset");
        step(1, 1'b1, 1'b1, 1'b1, 7'b0010000, 1'b0, 1'b0, 8'd0, "b_o1");
        step(1, 1'b1, 1'b1, 1'b1, 7'b0100000, 1'b0, 1'b0, 8'd0, "b_o2");
        step(1, 1'b1, 1'b1, 1'b1, 7'b1000000, 1'b1, 1'b1, 8'd1, "b_o3");
        step(1, 1'b1, 1'b1, 1'b1, 7'b0010000, 1'b0, 1'b0, 8'd1, "b_o1_restart");
        step(1, 1'b1, 1'b1, 1'b1, 7'b0100000, 1'b0, 1'b0, 8'd1, "b_o2b");
        step(1, 1'b1, 1'b1, 1'b1, 7'b1000000, 1'b1, 1'b1, 8'd2, "b_o3b");
        step(1, 1'b1, 1'b1, 1'b0, 7'b0000010, 1'b0, 1'b0, 8'd2, "b_z1");
        step(1, 1'b1, 1'b1, 1'b0, 7'b0000100, 1'b0, 1'b0, 8'd2, "b_z2");
        step(1, 1'b1, 1'b1, 1'b0, 7'b0001000, 1'b1, 1'b0, 8'd3, "b_z3");
        step(1, 1'b1, 1'b1, 1'b0, 7'b0000010, 1'b0, 1'b0, 8'd3, "b_z1_restart");

        // DUT c: RUN_LEN=2, overlap, 2-bit saturating counter
        step(2, 1'b0, 1'b1, 1'b1, 7'b0000001, 1'b0, 1'b0, 8'd0, "c_reset");
        step(2, 1'b1, 1'b1, 1'b0, 7'b0000010, 1'b0, 1'b0, 8'd0, "c_e1");
        step(2, 1'b1, 1'b1, 1'b0, 7'b0000100, 1'b1, 1'b0, 8'd1, "c_e2");
        step(2, 1'b1, 1'b1, 1'b0, 7'b0000100, 1'b1, 1'b0, 8'd2, "c_e3");
        step(2, 1'b1, 1'b1, 1'b0, 7'b0000100, 1'b1, 1'b0, 8'd3, "c_e4");
        step(2, 1'b1, 1'b1, 1'b0, 7'b0000100, 1'b1, 1'b0, 8'd3, "c_e5_sat");
        step(2, 1'b1, 1'b1, 1'b0, 7'b0000100, 1'b1, 1'b0, 8'd3, "c_e6_sat");
        step(2, 1'b1, 1'b1, 1'b0, 7'b0000100, 1'b1, 1'b0, 8'd3, "c_e7_sat");
        step(2, 1'b1, 1'b1, 1'b1, 7'b0001000, 1'b0, 1'b0, 8'd3, "c_o1_hold");

        // Drain the scoreboard within a bounded number of edges.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
